// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply / unsigned divide with valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready/op/a/b, out_valid/out_ready/result, busy. Option: MULDIV_SEQ_EARLY_OUT_EN.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int ITERS = WIDTH;
  localparam int CW    = $clog2(ITERS + 1);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res_q;

  logic             accept;
  logic             early;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] sh_step;
  logic [WIDTH-1:0] opb_step;
  logic [WIDTH-1:0] fin;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = res_q;
  assign accept    = in_valid && in_ready;

`ifdef MULDIV_SEQ_EARLY_OUT_EN
  always_comb begin
    early = 1'b0;
    unique case (1'b1)
      (op == OP_MUL):  early = (a == '0) || (b == '0);
      (op == OP_DIVU),
      (op == OP_REMU): early = (b == '0);
      default:         early = 1'b1;
    endcase
  end
`else
  assign early = 1'b0;
`endif

  // acc: product (MUL) or partial remainder (DIV/REM)
  // sh:  multiplier (MUL) or dividend shifting into quotient (DIV/REM)
  // opb: multiplicand shifting left (MUL) or divisor (DIV/REM)
  always_comb begin
    shifted  = {acc[WIDTH-1:0], sh[WIDTH-1]};
    diff     = shifted - {1'b0, opb};
    acc_step = acc;
    sh_step  = sh;
    opb_step = opb;
    unique case (1'b1)
      (op_q == OP_MUL): begin
        if (sh[0])
          acc_step = {1'b0, acc[WIDTH-1:0] + opb};
        sh_step  = sh >> 1;
        opb_step = opb << 1;
      end
      (op_q == OP_DIVU),
      (op_q == OP_REMU): begin
        if (!diff[WIDTH]) begin
          acc_step = diff;
          sh_step  = {sh[WIDTH-2:0], 1'b1};
        end else begin
          acc_step = shifted;
          sh_step  = {sh[WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // Division by zero yields 0 for both quotient and remainder.
  always_comb begin
    fin = '0;
    unique case (1'b1)
      (op_q == OP_MUL):  fin = acc[WIDTH-1:0];
      (op_q == OP_DIVU): fin = (opb != '0) ? sh : '0;
      (op_q == OP_REMU): fin = (opb != '0) ? acc[WIDTH-1:0] : '0;
      default:           fin = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An early-out op loads a zero count so it retires on the next edge;
  // its zeroed accumulator or zero divisor already forces a 0 result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      op_q  <= '0;
      acc   <= '0;
      sh    <= '0;
      opb   <= '0;
      res_q <= '0;
    end else if (accept) begin
      op_q <= op;
      acc  <= '0;
      cnt  <= early ? '0 : CW'(ITERS);
      if (op == OP_MUL) begin
        sh  <= b;
        opb <= a;
      end else begin
        sh  <= a;
        opb <= b;
      end
    end else if (state == BUSY) begin
      if (cnt != '0) begin
        acc <= acc_step;
        sh  <= sh_step;
        opb <= opb_step;
        cnt <= cnt - CW'(1);
      end else begin
        res_q <= fin;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed table-driven bench for muldiv_seq (WIDTH=32).
// Covers reset, all ops, div-by-zero, latency, backpressure, mid-op reset.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks;
  int failures;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          early;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic int exp_lat(input bit e);
`ifdef MULDIV_SEQ_EARLY_OUT_EN
    return e ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  // Issue one op, wait for out_valid, check latency/result, retire it.
  task automatic run_op(input int idx, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input int lat_req);
    int lat;
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 2'b11;
    a = 32'hdead_beef;
    b = 32'h1234_5678;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(lat_req));
    chk({nm, "_result"}, result, e);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_retire"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    bit seen;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;

    vecs[0]  = '{2'b00, 32'd7, 32'd6, 32'd42, 1'b0};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{2'b01, 32'd100, 32'd7, 32'd14, 1'b0};
    vecs[3]  = '{2'b10, 32'd100, 32'd7, 32'd2, 1'b0};
    vecs[4]  = '{2'b01, 32'd5, 32'd0, 32'd0, 1'b1};
    vecs[5]  = '{2'b10, 32'd5, 32'd0, 32'd0, 1'b1};
    vecs[6]  = '{2'b11, 32'd9, 32'd9, 32'd0, 1'b1};
    vecs[7]  = '{2'b00, 32'd0, 32'd5, 32'd0, 1'b1};
    vecs[8]  = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0};
    vecs[9]  = '{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{2'b10, 32'hFFFF_FFFF, 32'd10, 32'd5, 1'b0};
    vecs[11] = '{2'b01, 32'd7, 32'd100, 32'd0, 1'b0};
    vecs[12] = '{2'b10, 32'd7, 32'd100, 32'd7, 1'b0};
    vecs[13] = '{2'b00, 32'd12345, 32'd6789, 32'd83810205, 1'b0};
    vecs[14] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'd1, 1'b0};
    vecs[15] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 16; i++)
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             exp_lat(vecs[i].early));

    // Backpressure: result held, new requests ignored.
    @(negedge clk);
    in_valid = 1'b1;
    op = 2'b00;
    a = 32'd3;
    b = 32'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_latency", 32'(n), 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      op = 2'b01;
      a = 32'd50;
      b = 32'd2;
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d", i),
          {result[29:0], out_valid, in_ready}, {30'd15, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_retire", {29'd0, busy, out_valid, in_ready}, 32'd1);
    chk("bp_result_kept", result, 32'd15);

    // Reset in the middle of a division.
    @(negedge clk);
    in_valid = 1'b1;
    op = 2'b01;
    a = 32'd1000;
    b = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", {30'd0, out_valid, busy}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_no_done", 32'(seen), 32'd0);
    run_op(99, 2'b00, 32'd3, 32'd3, 32'd9, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; ITERS equals WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  requester presents an operation.
REQ-005 in_ready  output  1  block can accept; high only in IDLE.
REQ-006 op  input  2  00 MUL (low WIDTH bits), 01 DIVU, 10 REMU, 11 reserved.
REQ-007 a  input  WIDTH  operand A (dividend / multiplicand), unsigned.
REQ-008 b  input  WIDTH  operand B (divisor / multiplier), unsigned.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 result  output  WIDTH  registered result.
REQ-012 busy  output  1  high in BUSY or DONE.

Function
REQ-013 States: IDLE, BUSY, DONE; one-hot or binary, no other reachable state.
REQ-014 Accept = in_valid && in_ready at a rising edge; op, a, b captured into internal registers at that edge; inputs ignored afterwards.
REQ-015 IDLE -> BUSY on accept; iteration counter loaded with ITERS.
REQ-016 BUSY: one radix-2 step per cycle, counter decrements; BUSY -> DONE on the edge where counter reaches 0; out_valid first high exactly ITERS+1 edges after accept edge (33 for WIDTH=32).
REQ-017 MUL: shift-add, LSB of multiplier first; result = (a*b) mod 2^WIDTH.
REQ-018 DIVU/REMU: restoring division, MSB of dividend first; WIDTH+1-bit partial remainder; DIVU -> quotient, REMU -> remainder.
REQ-019 b == 0 for DIVU or REMU: result 0 (no all-ones quotient, no dividend remainder).
REQ-020 op 11: result 0, same latency as other ops.
REQ-021 DONE: out_valid = 1, result stable until out_valid && out_ready; DONE -> IDLE on that edge.
REQ-022 out_ready held low: remain in DONE indefinitely, in_ready low, no new accept.
REQ-023 out_ready high while in DONE on first cycle: single-cycle DONE; in_ready high the following cycle (no same-edge accept/retire).
REQ-024 in_valid while BUSY/DONE: ignored, no state change; requester must hold request.
REQ-025 out_ready while not DONE: no effect.
REQ-026 result updates only on BUSY -> DONE transition; otherwise holds.

Reset
REQ-027 rst_n low: immediately (asynchronously) state = IDLE, counter = 0, result = 0, out_valid = 0, busy = 0; in_ready = 1 once reset is deasserted.
REQ-028 Reset during BUSY or DONE abandons the operation; no out_valid pulse after release.
REQ-029 First accept possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro MULDIV_SEQ_EARLY_OUT_EN defined: on accept, if (MUL and (a == 0 or b == 0)) or (DIVU/REMU and b == 0) or op 11, go IDLE -> DONE directly with result 0; out_valid high 1 edge after accept.
REQ-031 Macro undefined: every op takes full ITERS+1 latency; results identical to REQ-017..REQ-020.

Verification
REQ-032 MUL a=7, b=6 -> out_valid on edge 33 after accept, result=42; with out_ready=1 back to IDLE, in_ready high next cycle.
REQ-033 MUL a=0xFFFF_FFFF, b=2 -> result=0xFFFF_FFFE; DIVU a=100, b=7 -> result=14; REMU a=100, b=7 -> result=2.
REQ-034 DIVU a=5, b=0 -> result=0; latency 33 without macro, 1 with MULDIV_SEQ_EARLY_OUT_EN.
REQ-035 Backpressure: out_ready=0 for 10 cycles after out_valid -> result, out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> retire, IDLE.
REQ-036 rst_n pulsed low at BUSY cycle 15 of DIVU -> out_valid=0, result=0 immediately; no completion afterwards; new MUL 3*3 after release -> result=9.
